// File: rtl/dmem_pkg.sv
// Shared definitions for the memory-stage access controller: FSM encodings,
// load/store select codes, the invalid-load sentinel and counter sizing.
package dmem_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  localparam logic [2:0] LSEL_LW  = 3'b000;
  localparam logic [2:0] LSEL_LB  = 3'b001;
  localparam logic [2:0] LSEL_LH  = 3'b010;
  localparam logic [2:0] LSEL_LBU = 3'b101;
  localparam logic [2:0] LSEL_LHU = 3'b110;

  localparam logic [1:0] SSEL_SW = 2'b00;
  localparam logic [1:0] SSEL_SB = 2'b01;
  localparam logic [1:0] SSEL_SH = 2'b10;

  localparam logic [31:0] LOAD_SENTINEL = 32'h2333_3333;

  typedef enum logic [1:0] {
    EXC_NONE,
    EXC_ADEL,
    EXC_ADES,
    EXC_BUS
  } exc_kind_e;

  // Wait counter must be able to hold the value TIMEOUT_CYC itself.
  function automatic int cnt_width(input int timeout_cyc);
    return $clog2(timeout_cyc + 1);
  endfunction

endpackage

// File: rtl/load_extract.sv
// Selects and extends the loaded byte/half/word from a 32-bit memory word.
// Purely combinational so the W stage can reuse it.
module load_extract
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  lsel,
  input  logic [1:0]  byte_off,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    byte_sel = word[7:0];
    case (byte_off)
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      2'd3:    byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    half_sel = byte_off[1] ? word[31:16] : word[15:0];

    result = LOAD_SENTINEL;
    case (lsel)
      LSEL_LW:  result = word;
      LSEL_LB:  result = {{24{byte_sel[7]}}, byte_sel};
      LSEL_LBU: result = {24'd0, byte_sel};
      LSEL_LH:  result = {{16{half_sel[15]}}, half_sel};
      LSEL_LHU: result = {16'd0, half_sel};
      default:  result = LOAD_SENTINEL;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// M-stage load/store controller: alignment check, byte lanes, req/ack bus
// handshake with timeout, pipeline stall and load-result extraction.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_lsel,
  input  logic [1:0]  req_ssel,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        flush,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        exc_bus,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int            CW       = cnt_width(TIMEOUT_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  logic [1:0]    state;
  logic [CW-1:0] wait_cnt;
  logic          squash;
  exc_kind_e     exc_kind;
  logic [2:0]    lsel_q;
  logic [1:0]    off_q;
  logic [31:0]   rdata_q;
  logic [31:0]   load_result;

  logic          accept;
  logic          misaligned;
  logic [3:0]    be_n;
  logic [31:0]   wdata_n;

  assign accept = (state == ST_IDLE) && req_valid && !flush;

  // Byte lanes, store-data replication and alignment for the incoming request.
  always_comb begin
    be_n       = 4'b1111;
    wdata_n    = req_wdata;
    misaligned = 1'b0;
    if (req_we) begin
      case (req_ssel)
        SSEL_SB: begin
          be_n    = 4'b0001 << req_addr[1:0];
          wdata_n = {4{req_wdata[7:0]}};
        end
        SSEL_SH: begin
          be_n       = req_addr[1] ? 4'b1100 : 4'b0011;
          wdata_n    = {2{req_wdata[15:0]}};
          misaligned = req_addr[0];
        end
        default: misaligned = (req_addr[1:0] != 2'b00);
      endcase
    end else begin
      case (req_lsel)
        LSEL_LW:            misaligned = (req_addr[1:0] != 2'b00);
        LSEL_LH, LSEL_LHU:  misaligned = req_addr[0];
        default:            misaligned = 1'b0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments and clears asynchronously on rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      squash    <= 1'b0;
      exc_kind  <= EXC_NONE;
      lsel_q    <= '0;
      off_q     <= '0;
      rdata_q   <= '0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            squash   <= 1'b0;
            wait_cnt <= '0;
            lsel_q   <= req_lsel;
            off_q    <= req_addr[1:0];
            if (misaligned) begin
              state    <= ST_FAULT;
              exc_kind <= req_we ? EXC_ADES : EXC_ADEL;
            end else begin
              state     <= ST_ISSUE;
              exc_kind  <= EXC_NONE;
              bus_we    <= req_we;
              bus_addr  <= {req_addr[31:2], 2'b00};
              bus_be    <= be_n;
              bus_wdata <= wdata_n;
            end
          end
        end
        ST_ISSUE: begin
          // A flush cannot abandon the bus cycle; it only hides the completion.
          if (flush) squash <= 1'b1;
          if (bus_ack) begin
            rdata_q <= bus_rdata;
            state   <= ST_DONE;
          end else if (wait_cnt == CNT_LAST) begin
            exc_kind <= EXC_BUS;
            state    <= ST_FAULT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  load_extract u_load_extract (
    .word     (rdata_q),
    .lsel     (lsel_q),
    .byte_off (off_q),
    .result   (load_result)
  );

  assign bus_req   = (state == ST_ISSUE);
  assign stall     = accept || (state == ST_ISSUE);
  assign rsp_valid = (state == ST_DONE) && !squash;
  assign rsp_rdata = ((state == ST_DONE) && !bus_we) ? load_result : 32'd0;
  assign exc_adel  = (state == ST_FAULT) && (exc_kind == EXC_ADEL);
  assign exc_ades  = (state == ST_FAULT) && (exc_kind == EXC_ADES);
  assign exc_bus   = (state == ST_FAULT) && (exc_kind == EXC_BUS) && !squash;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: a transaction-level model predicts
// every output cycle by cycle; directed cases pin the model with literal values.
module tb_dmem_access_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, flush = 1'b0;
  logic [2:0]  req_lsel = '0;
  logic [1:0]  req_ssel = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        stall, rsp_valid, exc_adel, exc_ades, exc_bus;
  logic [31:0] rsp_rdata;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;

  dmem_access_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
    .req_lsel(req_lsel), .req_ssel(req_ssel), .req_addr(req_addr),
    .req_wdata(req_wdata), .flush(flush), .stall(stall), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .exc_adel(exc_adel), .exc_ades(exc_ades),
    .exc_bus(exc_bus), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (spec-level arithmetic) ----------------
  function automatic int access_size(input logic we, input logic [2:0] lsel, input logic [1:0] ssel);
    if (we) return (ssel == 2'b01) ? 1 : (ssel == 2'b10) ? 2 : 4;
    if (lsel == 3'b000) return 4;
    if (lsel == 3'b010 || lsel == 3'b110) return 2;
    return 1;
  endfunction

  function automatic bit ref_misaligned(input logic we, input logic [2:0] lsel,
                                        input logic [1:0] ssel, input logic [31:0] addr);
    return (int'(addr[1:0]) % access_size(we, lsel, ssel)) != 0;
  endfunction

  function automatic logic [3:0] ref_be(input logic we, input logic [1:0] ssel, input logic [31:0] addr);
    int sz = access_size(we, 3'b000, ssel);
    if (!we || sz == 4) return 4'hF;
    return 4'((sz == 2 ? 3 : 1) << int'(addr[1:0]));
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] ssel, input logic [31:0] w);
    case (access_size(1'b1, 3'b000, ssel))
      1:       return w[7:0] * 32'h0101_0101;
      2:       return w[15:0] * 32'h0001_0001;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] ref_extract(input logic [31:0] w, input logic [2:0] lsel, input logic [1:0] off);
    logic [31:0] b = w >> (8 * int'(off));
    logic [31:0] h = w >> (16 * int'(off[1]));
    case (lsel)
      3'b000:  return w;
      3'b001:  return 32'($signed(b[7:0]));
      3'b101:  return {24'd0, b[7:0]};
      3'b010:  return 32'($signed(h[15:0]));
      3'b110:  return {16'd0, h[15:0]};
      default: return 32'h2333_3333;
    endcase
  endfunction

  // ---------------- per-cycle expectations and compare process ----------------
  bit          chk_en = 1'b0;
  logic        e_stall, e_req, e_rsp, e_adel, e_ades, e_bus, e_we;
  logic [31:0] e_addr, e_wdata, e_rdata;
  logic [3:0]  e_be;

  logic [31:0] obs_rdata = '0, obs_addr = '0, obs_wdata = '0;
  logic [3:0]  obs_be = '0;
  int          obs_rsp_cyc = 0, obs_exc_cyc = 0, req_cnt = 0, rsp_cnt = 0;

  task automatic idle_exp();
    {e_stall, e_req, e_rsp, e_adel, e_ades, e_bus, e_we} = '0;
    e_addr = '0; e_wdata = '0; e_rdata = '0; e_be = '0;
  endtask

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check("stall", 32'(stall), 32'(e_stall));
      check("bus_req", 32'(bus_req), 32'(e_req));
      check("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
      check("exc_adel", 32'(exc_adel), 32'(e_adel));
      check("exc_ades", 32'(exc_ades), 32'(e_ades));
      check("exc_bus", 32'(exc_bus), 32'(e_bus));
      if (e_req) begin
        check("bus_addr", bus_addr, e_addr);
        check("bus_be", 32'(bus_be), 32'(e_be));
        check("bus_we", 32'(bus_we), 32'(e_we));
        if (e_we) check("bus_wdata", bus_wdata, e_wdata);
      end
      if (e_rsp) check("rsp_rdata", rsp_rdata, e_rdata);
    end
    if (bus_req) begin
      req_cnt   <= req_cnt + 1;
      obs_addr  <= bus_addr;
      obs_be    <= bus_be;
      obs_wdata <= bus_wdata;
    end
    if (rsp_valid) begin
      rsp_cnt     <= rsp_cnt + 1;
      obs_rdata   <= rsp_rdata;
      obs_rsp_cyc <= cyc;
    end
    if (exc_adel || exc_ades || exc_bus) obs_exc_cyc <= cyc;
  end

  // One memory instruction from accept to completion; returns at the first idle cycle.
  task automatic do_op(input logic we, input logic [2:0] lsel, input logic [1:0] ssel,
                       input logic [31:0] addr, input logic [31:0] wdata, input int waits,
                       input logic [31:0] rdata, input int flush_at, output int acc_cyc);
    int  nreq;
    bit  squashed;
    req_valid = 1'b1; req_we = we; req_lsel = lsel; req_ssel = ssel;
    req_addr = addr; req_wdata = wdata; flush = 1'b0; bus_ack = 1'b0;
    idle_exp(); e_stall = 1'b1;
    acc_cyc = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    if (ref_misaligned(we, lsel, ssel, addr)) begin
      idle_exp(); e_adel = !we; e_ades = we;
      @(posedge clk); #1;
    end else begin
      nreq     = (waits < TO) ? waits + 1 : TO;
      squashed = flush_at < nreq;
      for (int i = 0; i < nreq; i++) begin
        idle_exp();
        e_stall = 1'b1; e_req = 1'b1; e_we = we;
        e_addr  = {addr[31:2], 2'b00};
        e_be    = ref_be(we, ssel, addr);
        e_wdata = ref_wdata(ssel, wdata);
        bus_ack   = (i == waits);
        bus_rdata = (i == waits) ? rdata : $urandom;
        flush     = (i == flush_at);
        @(posedge clk); #1;
      end
      // A stray ack in the completion cycle must be ignored.
      bus_ack = 1'($urandom_range(0, 1)); bus_rdata = $urandom;
      flush   = (flush_at == nreq);
      idle_exp();
      if (waits < TO) begin
        e_rsp   = !squashed;
        e_rdata = we ? 32'd0 : ref_extract(rdata, lsel, addr[1:0]);
      end else begin
        e_bus = !squashed;
      end
      @(posedge clk); #1;
    end
    idle_exp(); bus_ack = 1'b0; flush = 1'b0;
  endtask

  // Idle cycles with flushed requests and stray acks: nothing may happen.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      flush     = req_valid;
      bus_ack   = 1'($urandom_range(0, 1));
      req_addr  = $urandom;
      idle_exp();
      @(posedge clk); #1;
    end
    req_valid = 1'b0; flush = 1'b0; bus_ack = 1'b0;
  endtask

  initial begin
    int acc, r0, w, fa;
    logic [2:0] ls;
    logic [2:0] valid_lsel [5] = '{3'b000, 3'b001, 3'b010, 3'b101, 3'b110};

    check("pin_lb", ref_extract(32'h80FF_1234, 3'b001, 2'd3), 32'hFFFF_FF80);
    check("pin_lhu", ref_extract(32'hABCD_0000, 3'b110, 2'd2), 32'h0000_ABCD);
    check("pin_sb_be", 32'(ref_be(1'b1, 2'b01, 32'h5001)), 32'h2);
    check("pin_sh_data", ref_wdata(2'b10, 32'h0000_BEEF), 32'hBEEF_BEEF);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", 32'(stall), 0);
    check("rst_bus_req", 32'(bus_req), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_exc", 32'({exc_adel, exc_ades, exc_bus}), 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_be", 32'(bus_be), 0);
    check("rst_bus_wdata", bus_wdata, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    rst_n = 1'b1;
    idle_exp(); chk_en = 1'b1;
    @(posedge clk); #1;

    // lb 0x1003, zero waits
    req_cnt = 0;
    do_op(1'b0, 3'b001, 2'b00, 32'h1003, 32'h0, 0, 32'h80FF_1234, 99, acc);
    #1;
    check("lb_rdata", obs_rdata, 32'hFFFF_FF80);
    check("lb_latency", obs_rsp_cyc - acc, 2);
    check("lb_bus_addr", obs_addr, 32'h1000);
    check("lb_bus_be", 32'(obs_be), 32'hF);

    // sh 0x2002, three waits
    req_cnt = 0;
    do_op(1'b1, 3'b000, 2'b10, 32'h2002, 32'h0000_BEEF, 3, 32'h0, 99, acc);
    #1;
    check("sh_bus_be", 32'(obs_be), 32'hC);
    check("sh_bus_wdata", obs_wdata, 32'hBEEF_BEEF);
    check("sh_req_cycles", req_cnt, 4);
    check("sh_latency", obs_rsp_cyc - acc, 5);

    // Misaligned lw / sh
    req_cnt = 0;
    do_op(1'b0, 3'b000, 2'b00, 32'h3001, 32'h0, 0, 32'h0, 99, acc);
    #1;
    check("adel_cycle", obs_exc_cyc - acc, 1);
    do_op(1'b1, 3'b000, 2'b10, 32'h3001, 32'h1234, 0, 32'h0, 99, acc);
    #1;
    check("ades_cycle", obs_exc_cyc - acc, 1);
    check("misaligned_no_bus", req_cnt, 0);

    // Timeout, then a late ack in idle
    req_cnt = 0;
    do_op(1'b0, 3'b000, 2'b00, 32'h0000_0040, 32'h0, 10, 32'h0, 99, acc);
    #1;
    check("timeout_req_cycles", req_cnt, TO);
    check("timeout_exc_cycle", obs_exc_cyc - acc, TO + 1);
    bus_ack = 1'b1; idle_exp();
    @(posedge clk); #1;
    bus_ack = 1'b0;

    // Ack in the very cycle the counter would expire: ack wins
    do_op(1'b0, 3'b000, 2'b00, 32'h0000_0010, 32'h0, TO - 1, 32'h1234_5678, 99, acc);
    #1;
    check("boundary_rdata", obs_rdata, 32'h1234_5678);
    check("boundary_latency", obs_rsp_cyc - acc, TO + 1);

    // Flushed lhu completes silently, next lbu proceeds
    r0 = rsp_cnt;
    do_op(1'b0, 3'b110, 2'b00, 32'h4002, 32'h0, 2, 32'hABCD_0000, 1, acc);
    #1;
    check("flush_no_rsp", rsp_cnt - r0, 0);
    do_op(1'b0, 3'b101, 2'b00, 32'h4001, 32'h0, 0, 32'h0000_8000, 99, acc);
    #1;
    check("after_flush_lbu", obs_rdata, 32'h0000_0080);

    idle_cycles(4);

    // Randomized traffic against the model
    for (int n = 0; n < 120; n++) begin
      logic we;
      we = 1'($urandom_range(0, 1));
      ls = ($urandom_range(0, 9) < 8) ? valid_lsel[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
      w  = $urandom_range(0, 5);
      fa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : 99;
      do_op(we, ls, 2'($urandom_range(0, 3)), $urandom, $urandom, w, $urandom, fa, acc);
      idle_cycles($urandom_range(0, 2));
    end

    // Reset in the middle of a bus transaction
    req_valid = 1'b1; req_we = 1'b0; req_lsel = 3'b000; req_addr = 32'h100;
    idle_exp(); e_stall = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    idle_exp(); e_stall = 1'b1; e_req = 1'b1; e_addr = 32'h100; e_be = 4'hF;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk_en = 1'b0;
    check("midrst_bus_req", 32'(bus_req), 0);
    check("midrst_stall", 32'(stall), 0);
    @(posedge clk); #1;
    rst_n = 1'b1; idle_exp(); chk_en = 1'b1;
    @(posedge clk); #1;
    do_op(1'b1, 3'b000, 2'b01, 32'h5001, 32'h0000_00A5, 1, 32'h0, 99, acc);
    #1;
    check("post_rst_sb_be", 32'(obs_be), 32'h2);
    check("post_rst_sb_data", obs_wdata, 32'hA5A5_A5A5);

    idle_cycles(2);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Memory-stage load/store controller for the MIPS pipeline. Accepts one memory operation per instruction from the M stage, checks alignment, and generates byte enables and lane-replicated store data. Runs a req/ack handshake with a variable-latency data memory, stalling the pipeline until completion. Returns the sign- or zero-extended load result, or raises an address/bus exception.

## Interface
- `TIMEOUT_CYC`, default 255: bus wait cycles allowed before a bus error (1..1023).
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: reset; asynchronous, active-low.
- `req_valid`  in  1: M stage holds a memory instruction.
- `req_we`  in  1: 1 = store, 0 = load.
- `req_lsel`  in  3: load select:
  - 000 lw, 001 lb, 010 lh, 101 lbu, 110 lhu.
- `req_ssel`  in  2: store select: 00 sw, 01 sb, 10 sh.
- `req_addr`  in  32: byte address.
- `req_wdata`  in  32: store data, right-justified.
- `flush`  in  1: squash the current M-stage instruction.
- `stall`  out  1: freeze IF..M.
- `rsp_valid`  out  1: one-cycle completion pulse.
- `rsp_rdata`  out  32: extended load result; valid with `rsp_valid` and a load.
- `exc_adel` / `exc_ades` / `exc_bus`  out  1 each: one-cycle exception pulses.
- `bus_req`  out  1: memory request.
- `bus_we`  out  1: memory write enable.
- `bus_addr`  out  32: word address, bits [1:0] = 00.
- `bus_be`  out  4: byte enables.
- `bus_wdata`  out  32: write data.
- `bus_ack`  in  1: memory completion.
- `bus_rdata`  in  32: read word, valid when `bus_ack` = 1.

## Operation
- States:
  - IDLE: no operation in flight.
  - ISSUE: `bus_req` held until ack or timeout.
  - DONE: completion cycle.
  - FAULT: exception cycle.
- IDLE, `req_valid` = 1, `flush` = 0:
  - Aligned → ISSUE; registers `bus_addr` = {addr[31:2], 00}, `bus_we`, `bus_be`, `bus_wdata`, and lsel/addr[1:0] for extraction.
  - Misaligned → FAULT; no bus transaction.
  - `flush` = 1 in IDLE: no acceptance.
- Alignment rules:
  - lw/sw fault if addr[1:0] ≠ 00.
  - lh/lhu/sh fault if addr[0] = 1.
  - Byte operations never fault.
- Store lanes:
  - sw: be = 1111, data as given.
  - sh: be = 0011 (addr[1] = 0) or 1100 (addr[1] = 1); data = {2{wdata[15:0]}}.
  - sb: be = 0001 << addr[1:0]; data = {4{wdata[7:0]}}.
- Loads: be = 1111, we = 0.
- Invalid `req_ssel` 11 is treated as sw.
- ISSUE:
  - `bus_req` = 1 with address, be, data and we held stable.
  - On `bus_ack`: capture `bus_rdata`, go to DONE.
  - Wait counter increments each non-ack cycle; on reaching `TIMEOUT_CYC`, drop `bus_req` and go to FAULT with bus error.
- `flush` during ISSUE cannot cancel the bus transaction. It sets a squash flag; `rsp_valid` and `exc_bus` are suppressed at completion.
- DONE: `rsp_valid` = 1 unless squashed, then → IDLE.
- Load extraction by lsel and registered addr[1:0]:
  - lb/lbu select byte lane addr[1:0], sign- or zero-extended.
  - lh/lhu select the half at addr[1], sign- or zero-extended.
  - lw passes the word.
  - Other lsel codes give 32'h2333_3333.
  - For stores, `rsp_rdata` = 0.
- FAULT: pulse exactly one of `exc_adel` (misaligned load), `exc_ades` (misaligned store), `exc_bus` (timeout); then → IDLE.
- Reset (async, `rst_n` = 0):
  - State → IDLE; all outputs 0; counter and squash flag cleared.
  - Mid-transaction reset drops `bus_req` immediately; memory must tolerate an abandoned request.

## Timing
- `stall` = 1 in IDLE while accepting (combinational on `req_valid`, `!flush`, state) and throughout ISSUE.
- `stall` = 0 in DONE and FAULT, so the pipeline advances in the completion cycle.
- Minimum load/store latency, with ack in the first request cycle:
  - Cycle 0: accept, `stall` = 1.
  - Cycle 1: `bus_req` = 1, `bus_ack` = 1.
  - Cycle 2: DONE, `rsp_valid` = 1, `stall` = 0.
  - Cycle 3: IDLE, ready for the next instruction.
- With N wait cycles, `rsp_valid` occurs in cycle 2+N.
- Misaligned access: accept in cycle 0 (`stall` = 1), exception pulse in cycle 1 (`stall` = 0).
- Back-to-back memory instructions are spaced at least 3 cycles apart.
- `bus_ack` outside ISSUE is ignored.
- `bus_ack` in the same cycle the counter reaches `TIMEOUT_CYC`: the ack wins.

## Structure
- Shared package `dmem_pkg`:
  - State encodings.
  - LSEL_* and SSEL_* constants.
  - Sentinel 32'h2333_3333.
  - Counter width $clog2(TIMEOUT_CYC+1).
- One combinational sub-module, `load_extract`: (word, lsel, addr[1:0]) → 32-bit result, also reusable in the W stage.
- Byte-enable and alignment logic lives in the top module.

## Test plan
- lb at addr 0x1003, ack after 0 waits, rdata 0x80FF_1234 → cycle 2 `rsp_valid`, `rsp_rdata` 0xFFFF_FF80; `bus_addr` 0x1000, `bus_be` 1111.
- sh at addr 0x2002, wdata 0x0000_BEEF, 3 wait cycles → `bus_be` 1100, `bus_wdata` 0xBEEF_BEEF held stable 4 cycles; `rsp_valid` in cycle 5.
- lw at addr 0x3001 → no `bus_req`; `exc_adel` pulse cycle 1. sh at 0x3001 → `exc_ades` pulse.
- `TIMEOUT_CYC` = 4, no ack → `bus_req` high 4 cycles then low, `exc_bus` pulse, `stall` released; ack arriving later is ignored.
- lhu at 0x4002, `flush` asserted in ISSUE, rdata 0xABCD_0000 → transaction completes, `rsp_valid` stays 0; the next lbu proceeds normally.
- `rst_n` low during ISSUE → `bus_req`, `stall` = 0 immediately; after release, a new sb at 0x5001 gives `bus_be` 0010.
